bcd_display_scan: RTL and testbench

- Downstream consumer of the 4-digit BCD converter.
- Captures a 16-bit packed BCD word on a one-cycle load strobe and time-multiplexes it onto the board's 4-digit common-anode seven-segment display.
- Provides tear-free updates at frame boundaries, anti-ghost blanking, leading-zero suppression, an invalid-nibble dash, and per-digit decimal points.

---
 rtl/bcd_display_scan.sv | 156 +++++++++++++++
 tb/tb_bcd_display_scan.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_scan.sv
// bcd_display_scan
//   Captures a packed 4-digit BCD word on a load strobe and time-multiplexes it
//   onto a 4-digit common-anode seven-segment display. New values are held in a
//   shadow register and swapped into the display register only at the end of a
//   full scan frame, so a frame never shows a mix of old and new digits.
//
// Ports
//   clk       system clock
//   rst       asynchronous reset, active-low
//   load      one-cycle strobe qualifying bcd_in
//   bcd_in    packed BCD, [3:0] = digit0 (least significant) .. [15:12] = digit3
//   dp        per-digit decimal point enable, active-high, sampled live
//   blank_lz  leading-zero blanking enable, sampled live
//   an        anode enables, active-low, an[i] drives digit i
//   seg       segments {g,f,e,d,c,b,a}, active-low
//   dp_n      decimal point, active-low
//   pending   a captured value is waiting for the frame-boundary swap
module bcd_display_scan #(
    parameter int unsigned REFRESH_DIV  = 1000,
    parameter int unsigned DIV_WIDTH    = 16,
    parameter int unsigned BLANK_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] bcd_in,
    input  logic [3:0]  dp,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic        pending
);

    localparam logic [DIV_WIDTH-1:0] TC_VAL    = DIV_WIDTH'(REFRESH_DIV - 1);
    localparam logic [DIV_WIDTH-1:0] BLANK_VAL = DIV_WIDTH'(BLANK_CYCLES);

    logic [DIV_WIDTH-1:0] r_presc;
    logic [1:0]           r_idx;
    logic [15:0]          r_disp;
    logic [15:0]          r_shadow;
    logic                 r_pending;
    logic [3:0]           r_an;
    logic [6:0]           r_seg;
    logic                 r_dp_n;

    logic                 w_tc;
    logic                 w_fb;
    logic [3:0]           w_nib;
    logic [3:0]           w_lz;
    logic                 w_digit_blank;
    logic                 w_window;
    logic [3:0]           w_an_nxt;
    logic [6:0]           w_seg_nxt;
    logic                 w_dp_n_nxt;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'd0:    seg_decode = 7'h40;
            4'd1:    seg_decode = 7'h79;
            4'd2:    seg_decode = 7'h24;
            4'd3:    seg_decode = 7'h30;
            4'd4:    seg_decode = 7'h19;
            4'd5:    seg_decode = 7'h12;
            4'd6:    seg_decode = 7'h02;
            4'd7:    seg_decode = 7'h78;
            4'd8:    seg_decode = 7'h00;
            4'd9:    seg_decode = 7'h10;
            default: seg_decode = 7'h3F;  // non-BCD nibble shows a dash
        endcase
    endfunction

    assign w_tc = (r_presc == TC_VAL);
    assign w_fb = w_tc && (r_idx == 2'd3);

    // Prescaler and digit index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_tc) begin
            r_presc <= '0;
            r_idx   <= r_idx + 2'd1;
        end else begin
            r_presc <= r_presc + DIV_WIDTH'(1);
        end
    end

    // Capture into shadow; swap into display only at the frame boundary.
    // A load coinciding with the boundary bypasses the shadow entirely.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_disp    <= '0;
            r_shadow  <= '0;
            r_pending <= 1'b0;
        end else if (w_fb) begin
            if (load) begin
                r_disp <= bcd_in;
            end else if (r_pending) begin
                r_disp <= r_shadow;
            end
            r_pending <= 1'b0;
        end else if (load) begin
            r_shadow  <= bcd_in;
            r_pending <= 1'b1;
        end
    end

    always_comb begin
        case (r_idx)
            2'd0:    w_nib = r_disp[3:0];
            2'd1:    w_nib = r_disp[7:4];
            2'd2:    w_nib = r_disp[11:8];
            default: w_nib = r_disp[15:12];
        endcase
    end

    // w_lz[i]: digit i and every more significant digit are zero.
    // Digit 0 is never a leading zero.
    assign w_lz[3] = (r_disp[15:12] == 4'd0);
    assign w_lz[2] = w_lz[3] && (r_disp[11:8] == 4'd0);
    assign w_lz[1] = w_lz[2] && (r_disp[7:4] == 4'd0);
    assign w_lz[0] = 1'b0;

    assign w_digit_blank = blank_lz && w_lz[r_idx];
    assign w_window      = (r_presc < BLANK_VAL);

    always_comb begin
        w_an_nxt   = '1;
        w_seg_nxt  = '1;
        w_dp_n_nxt = 1'b1;
        if (!w_window && !w_digit_blank) begin
            w_an_nxt   = ~(4'b0001 << r_idx);
            w_seg_nxt  = seg_decode(w_nib);
            w_dp_n_nxt = ~dp[r_idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_an   <= '1;
            r_seg  <= '1;
            r_dp_n <= 1'b1;
        end else begin
            r_an   <= w_an_nxt;
            r_seg  <= w_seg_nxt;
            r_dp_n <= w_dp_n_nxt;
        end
    end

    assign an      = r_an;
    assign seg     = r_seg;
    assign dp_n    = r_dp_n;
    assign pending = r_pending;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Testbench for bcd_display_scan: randomized and directed stimulus, expected
// outputs from a cycle-count based reference model pushed to a queue and
// popped by an independent monitor every cycle.
module tb_bcd_display_scan;

    localparam int R = 16;
    localparam int B = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [15:0] bcd_in = '0;
    logic [3:0]  dp = '0;
    logic        blank_lz = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
    logic        pending;

    bcd_display_scan #(
        .REFRESH_DIV (R),
        .DIV_WIDTH   (4),
        .BLANK_CYCLES(B)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .bcd_in  (bcd_in),
        .dp      (dp),
        .blank_lz(blank_lz),
        .an      (an),
        .seg     (seg),
        .dp_n    (dp_n),
        .pending (pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp_n;
        logic       pending;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_cyc    = 0;

    // Controls applied to the DUT at the next negedge by step().
    logic       c_rst = 1'b0;
    logic [3:0] c_dp  = '0;
    logic       c_blz = 1'b0;

    // Reference model: time since reset, shown value, queued value.
    int unsigned m_t      = 0;
    logic [15:0] m_disp   = '0;
    logic [15:0] m_shadow = '0;
    logic        m_pend   = 1'b0;

    logic [6:0] SEG_TAB [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    function automatic logic [6:0] seg_of(input int v);
        if (v > 9) return 7'h3F;
        return SEG_TAB[v];
    endfunction

    // One clock: apply inputs at negedge, predict what the outputs hold
    // after the following posedge, then advance the model.
    task automatic step(input logic l, input logic [15:0] b);
        exp_t e;
        int   presc;
        int   idx;
        int   upper;
        @(negedge clk);
        rst      = c_rst;
        dp       = c_dp;
        blank_lz = c_blz;
        load     = l;
        bcd_in   = b;
        e.an      = 4'hF;
        e.seg     = 7'h7F;
        e.dp_n    = 1'b1;
        e.pending = 1'b0;
        if (!c_rst) begin
            m_t      = 0;
            m_disp   = '0;
            m_shadow = '0;
            m_pend   = 1'b0;
        end else begin
            presc = int'(m_t % R);
            idx   = int'((m_t / R) % 4);
            upper = int'(m_disp >> (4 * idx));
            if (presc >= B && !(c_blz && idx > 0 && upper == 0)) begin
                e.an   = ~(4'b0001 << idx);
                e.seg  = seg_of(upper & 15);
                e.dp_n = ~c_dp[idx];
            end
            if (presc == R - 1 && idx == 3) begin
                if (l) m_disp = b;
                else if (m_pend) m_disp = m_shadow;
                m_pend = 1'b0;
            end else if (l) begin
                m_shadow = b;
                m_pend   = 1'b1;
            end
            m_t++;
            e.pending = m_pend;
        end
        q.push_back(e);
    endtask

    task automatic run(input int n);
        repeat (n) step(1'b0, 16'h0000);
    endtask

    // Advance until the next edge sees the given prescaler/index.
    task automatic seek(input int presc, input int idx, input string name);
        int k;
        for (k = 0; k < 5 * R; k++) begin
            if (int'(m_t % R) == presc && int'((m_t / R) % 4) == idx) break;
            step(1'b0, 16'h0000);
        end
        if (k == 5 * R) begin
            n_checks++;
            $display("FAIL seek_%s: position p=%0d i=%0d not reached, wanted p=%0d i=%0d",
                     name, m_t % R, (m_t / R) % 4, presc, idx);
        end
    endtask

    // Monitor: every cycle the DUT presents a fresh registered output.
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(posedge clk);
            #1;
            n_cyc++;
            if (q.size() > 0) begin
                e   = q.pop_front();
                got = {an, seg, dp_n, pending};
                n_checks++;
                if (got === e) n_pass++;
                else
                    $display("FAIL scan cyc=%0d: got an=%h seg=%h dp_n=%b pending=%b, expected an=%h seg=%h dp_n=%b pending=%b",
                             n_cyc, got.an, got.seg, got.dp_n, got.pending,
                             e.an, e.seg, e.dp_n, e.pending);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle display of 0000 with blank_lz=0.
        c_rst = 1'b0;
        run(3);
        c_rst = 1'b1;
        run(70);

        // Scan order for 1234.
        step(1'b1, 16'h1234);
        run(140);

        // Tear-free: two loads within one frame, last one wins at FB.
        seek(5, 1, "tear1");
        step(1'b1, 16'h1234);
        run(10);
        seek(3, 3, "tear2");
        step(1'b1, 16'h5678);
        run(100);

        // Load exactly on the frame boundary.
        seek(R - 1, 3, "fb");
        step(1'b1, 16'h0009);
        run(70);

        // Leading zero blanking, decimal points, dash.
        c_blz = 1'b1;
        c_dp  = 4'hF;
        run(70);
        step(1'b1, 16'h00A0);
        run(140);
        step(1'b1, 16'h0000);
        run(130);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 31) == 0) c_blz = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) c_dp = 4'($urandom);
            if ($urandom_range(0, 11) == 0) step(1'b1, 16'($urandom));
            else step(1'b0, 16'($urandom));
        end

        // Reset during digit 2 with a capture pending.
        c_blz = 1'b0;
        c_dp  = 4'h5;
        seek(4, 0, "rst0");
        step(1'b1, 16'h4321);
        seek(6, 2, "rst2");
        c_rst = 1'b0;
        step(1'b0, 16'h0000);
        #1;
        n_checks++;
        if (an === 4'hF && seg === 7'h7F && dp_n === 1'b1 && pending === 1'b0) n_pass++;
        else
            $display("FAIL async_reset: got an=%h seg=%h dp_n=%b pending=%b, expected an=F seg=7F dp_n=1 pending=0",
                     an, seg, dp_n, pending);
        run(2);
        c_rst = 1'b1;
        run(80);

        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d expectations left, expected 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
